psram_opi_engine: RTL
=====================

Name: psram_opi_engine

Overview:
- Next-generation OPI PSRAM transaction engine. Executes complete command, address, wait and data sequences for read, write and config-register-write transfers.
- Adds a parametrised burst length, a ready/valid request handshake, a read-data return path and a real completion pulse.
- Sits between the PSRAM register/bus front-end and the octal pads.
- Runs in DDR mode: each SCK edge transfers one byte.

Parameters:
- MAX_BYTES, 4: maximum data bytes per transfer. Must be a power of 2, ≥1.
- PSCR_WIDTH, 8: prescaler width.
- ADDR_WIDTH, 32: address width. Must be a multiple of 8. Sent as ADDR_WIDTH/8 beats.
- LEN_WIDTH, $clog2(MAX_BYTES+1): width of the length field.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset. Synchronous, active-high.
- en_i  in  1  engine enable. When low, no new request is accepted.
- req_valid_i  in  1  request valid
- req_ready_o  out  1  high in IDLE when en_i=1
- req_wr_i  in  1  1=write, 0=read
- req_cfg_i  in  1  config-register write (overrides req_wr_i)
- req_addr_i  in  ADDR_WIDTH  byte address
- req_len_i  in  LEN_WIDTH  data bytes, 1..MAX_BYTES. 0 is treated as 1; values above MAX_BYTES are clamped to MAX_BYTES.
- req_wdata_i  in  8*MAX_BYTES  write data. Byte k is [8k+:8]; byte 0 is sent first.
- pscr_i  in  PSCR_WIDTH  half-SCK period minus 1, in clk_i cycles
- wr_cmd_i, rd_cmd_i, cfg_cmd_i  in  8 each  opcodes
- wrw_i, rdw_i  in  8 each  write/read latency in SCK cycles
- crm_o  out  2  constant OPI mode code
- busy_o  out  1  high when not IDLE
- done_o  out  1  single-cycle completion pulse
- rdata_o  out  8*MAX_BYTES  read data. Valid when done_o=1; held until the next accept.
- psram_sck_o  out  1  serial clock
- psram_ce_o  out  1  chip enable, active-low
- psram_io_en_o  out  8  output enables
- psram_io_in_i  in  8  pad input
- psram_io_out_o  out  8  pad output

Behaviour:
- Reset values: ce=1, sck=0, io_en=0, io_out=0, done=0, busy=0, rdata=0, FSM=IDLE. Reset mid-transfer aborts immediately; no done pulse is issued.
- Accept occurs when req_valid_i & req_ready_o. On accept the engine latches all req_* fields, opcodes, pscr_i, wrw_i and rdw_i; later changes to these inputs are ignored until the next accept.
- FSM states: IDLE -> CMD -> ADDR -> WAIT -> DATA -> END -> IDLE. WAIT is skipped when its beat count is 0 and for cfg writes.
- Beat counts:
  - CMD: 2 beats, opcode sent on both beats.
  - ADDR: ADDR_WIDTH/8 beats, MSB first.
  - WAIT: 2*wrw_i (write) or 2*rdw_i (read); 0 for cfg.
  - DATA: len for read/write; 1 for cfg (req_wdata_i[7:0]).
  - If the total beat count N is odd, one pad beat is appended with io_out=0, so SCK always ends low.
- Timing, with accept at cycle T:
  - T+1: ce=0, sck=0, io_out = beat-0 byte.
  - Prescaler is loaded with pscr at accept, decrements while ce=0, and reloads on 0.
  - SCK edge b occurs at T+1+pscr+b*(pscr+1).
  - io_out advances to beat b+1 one clk after edge b.
  - Cycle after the final edge: ce=1, done_o=1, FSM=END. IDLE follows on the next cycle.
  - done_o therefore pulses at T+1+N*(pscr+1).
- io_en=8'hFF during CMD, ADDR, write/cfg WAIT, DATA and pad beats. io_en=0 during read WAIT/DATA.
- Read capture: data byte k is sampled from psram_io_in_i on the clk where the prescaler expires inside data beat k (the cycle of edge k+1, or the final edge). Bytes at index ≥ len are zero.
- pscr_i=0 is legal: SCK toggles every clk. The 1-clk io_out advance still applies.
- Back-to-back transfers: a new accept is only possible in IDLE, so minimum CE-high time is 2 clk.
- crm_o is always the OPI code.

Decomposition:
- Shared define header/package holds:
  - PSCR width
  - mode codes (OPI)
  - FSM state encoding (IDLE, CMD, ADDR, WAIT, DATA, END)
  - CMD beat count
- Sub-module psram_sck_gen: prescaler counter plus SCK toggle register, with an edge strobe output. Inputs: run, pscr, clear.
- The engine FSM, beat counter and shift/capture logic stay in psram_opi_engine.

Test Plan:
1. Read, len=4, rdw=6, pscr=1, addr=32'h0000_1234.
   - Expected: N=22. io_out sequence is rd_cmd, rd_cmd, 00, 00, 12, 34. io_en=0 from beat 6.
   - Model drives AA, BB, CC, DD in the data beats -> rdata_o=32'hDDCC_BBAA. done at T+45.
2. Write, len=1, wrw=3, pscr=0, wdata byte 0=8'h5A.
   - Expected: N=13, padded to 14. 5A on beat 12, 00 on beat 13. done at T+15. sck ends 0.
3. Cfg write, cfg_cmd=8'hC0, addr=0, wdata[7:0]=8'h0B, pscr=2.
   - Expected: no WAIT. N=7, padded to 8. done at T+25.
4. Handshake and enable.
   - en_i=0 with req_valid_i=1 -> req_ready_o=0 and ce stays 1.
   - Raise en_i -> accept.
   - Change pscr_i and opcodes mid-transfer -> no effect on the waveform.
5. Reset mid-transfer: rst_i=1 during DATA.
   - Expected: next cycle ce=1, sck=0, io_en=0, no done pulse.
   - A new request after release completes normally.
6. Edge length: req_len_i=0 behaves as len=1.
   - Back-to-back requests -> ce high for ≥2 clk between transfers.

Source files
------------

// File: rtl/psram_opi_engine_pkg.sv
// Shared constants and types for the OPI PSRAM transaction engine and its SCK generator.
package psram_opi_engine_pkg;

    localparam int PSCR_W    = 8;
    localparam int CMD_BEATS = 2;
    // Beat index width: the longest phase is a 2*255-beat latency wait.
    localparam int IDX_W     = 9;

    localparam logic [1:0] CRM_OPI = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WAIT,
        ST_DATA,
        ST_END
    } state_t;

    typedef enum logic [1:0] {
        XFER_RD,
        XFER_WR,
        XFER_CFG
    } xfer_t;

endpackage

// File: rtl/psram_sck_gen.sv
// Prescaled SCK generator: toggles SCK each time the down-counter expires and strobes tick_o.
module psram_sck_gen
    import psram_opi_engine_pkg::*;
#(
    parameter int PSCR_WIDTH = PSCR_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  run_i,
    input  logic                  clear_i,
    input  logic [PSCR_WIDTH-1:0] pscr_i,
    output logic                  sck_o,
    output logic                  tick_o
);

    logic [PSCR_WIDTH-1:0] cnt_q;

    assign tick_o = run_i && (cnt_q == '0);

    // NOTE: sequential state uses <= so every register sees the pre-edge values of the others.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            sck_o <= 1'b0;
        end else if (clear_i) begin
            cnt_q <= pscr_i;
            sck_o <= 1'b0;
        end else if (tick_o) begin
            cnt_q <= pscr_i;
            sck_o <= ~sck_o;
        end else if (run_i) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/psram_opi_engine.sv
// OPI PSRAM transaction engine: sequences CMD/ADDR/WAIT/DATA beats in DDR mode, one byte per SCK edge.
module psram_opi_engine
    import psram_opi_engine_pkg::*;
#(
    parameter int MAX_BYTES  = 4,
    parameter int PSCR_WIDTH = PSCR_W,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_wr_i,
    input  logic                   req_cfg_i,
    input  logic [ADDR_WIDTH-1:0]  req_addr_i,
    input  logic [LEN_WIDTH-1:0]   req_len_i,
    input  logic [8*MAX_BYTES-1:0] req_wdata_i,
    input  logic [PSCR_WIDTH-1:0]  pscr_i,
    input  logic [7:0]             wr_cmd_i,
    input  logic [7:0]             rd_cmd_i,
    input  logic [7:0]             cfg_cmd_i,
    input  logic [7:0]             wrw_i,
    input  logic [7:0]             rdw_i,
    output logic [1:0]             crm_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [8*MAX_BYTES-1:0] rdata_o,
    output logic                   psram_sck_o,
    output logic                   psram_ce_o,
    output logic [7:0]             psram_io_en_o,
    input  logic [7:0]             psram_io_in_i,
    output logic [7:0]             psram_io_out_o
);

    localparam int ADDR_BEATS = ADDR_WIDTH / 8;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d, last_idx;
    logic                   accept, active, sck_tick, beat_last, final_edge, capture;

    xfer_t                  kind_q, req_kind;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [8*MAX_BYTES-1:0] wdata_q;
    logic [PSCR_WIDTH-1:0]  pscr_q;
    logic [7:0]             cmd_q, req_cmd;
    logic [IDX_W-1:0]       wait_q, req_wait;
    logic [LEN_WIDTH-1:0]   dlen_q, req_dlen;
    logic                   pad_q, req_pad;
    logic [7:0]             io_en_d, io_out_d;

    assign crm_o       = CRM_OPI;
    assign busy_o      = (state_q != ST_IDLE);
    assign req_ready_o = (state_q == ST_IDLE) && en_i;
    assign accept      = req_valid_i && req_ready_o;
    assign active      = state_q inside {ST_CMD, ST_ADDR, ST_WAIT, ST_DATA};

    psram_sck_gen #(
        .PSCR_WIDTH (PSCR_WIDTH)
    ) u_sck_gen (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .run_i   (active),
        .clear_i (accept),
        .pscr_i  (accept ? pscr_i : pscr_q),
        .sck_o   (psram_sck_o),
        .tick_o  (sck_tick)
    );

    // Decode the incoming request; only used on the accept cycle.
    // NOTE: every variable driven here gets a default first, so no latch can be inferred.
    always_comb begin
        req_kind = XFER_RD;
        req_cmd  = rd_cmd_i;
        req_wait = IDX_W'({rdw_i, 1'b0});
        req_dlen = req_len_i;
        if (req_cfg_i) begin
            req_kind = XFER_CFG;
            req_cmd  = cfg_cmd_i;
            req_wait = '0;
        end else if (req_wr_i) begin
            req_kind = XFER_WR;
            req_cmd  = wr_cmd_i;
            req_wait = IDX_W'({wrw_i, 1'b0});
        end
        if (req_cfg_i || (req_len_i == '0)) begin
            req_dlen = LEN_WIDTH'(1);
        end else if (req_len_i > LEN_WIDTH'(MAX_BYTES)) begin
            req_dlen = LEN_WIDTH'(MAX_BYTES);
        end
        // CMD and WAIT are always even, so parity comes from ADDR plus DATA.
        req_pad = 1'(ADDR_BEATS % 2) ^ req_dlen[0];
    end

    always_comb begin
        last_idx = '0;
        case (state_q)
            ST_CMD:  last_idx = IDX_W'(CMD_BEATS - 1);
            ST_ADDR: last_idx = IDX_W'(ADDR_BEATS - 1);
            ST_WAIT: last_idx = wait_q - 1'b1;
            ST_DATA: last_idx = IDX_W'(dlen_q) + IDX_W'(pad_q) - 1'b1;
            default: last_idx = '0;
        endcase
    end

    assign beat_last  = (idx_q == last_idx);
    assign final_edge = (state_q == ST_DATA) && sck_tick && beat_last;
    assign capture    = (state_q == ST_DATA) && sck_tick && (kind_q == XFER_RD)
                        && (idx_q < IDX_W'(dlen_q));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_CMD;
                    idx_d   = '0;
                end
            end
            ST_END: state_d = ST_IDLE;
            default: begin
                if (sck_tick) begin
                    if (beat_last) begin
                        idx_d = '0;
                        case (state_q)
                            ST_CMD:  state_d = ST_ADDR;
                            ST_ADDR: state_d = (wait_q != '0) ? ST_WAIT : ST_DATA;
                            ST_WAIT: state_d = ST_DATA;
                            default: state_d = ST_END;
                        endcase
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
        endcase
    end

    // Pad drive for the beat that will be current next cycle; beat 0 comes straight from the request.
    always_comb begin
        io_en_d  = 8'h00;
        io_out_d = 8'h00;
        if (accept) begin
            io_en_d  = 8'hFF;
            io_out_d = req_cmd;
        end else begin
            case (state_d)
                ST_CMD: begin
                    io_en_d  = 8'hFF;
                    io_out_d = cmd_q;
                end
                ST_ADDR: begin
                    io_en_d  = 8'hFF;
                    io_out_d = 8'(addr_q >> (8 * (ADDR_BEATS - 1 - int'(idx_d))));
                end
                ST_WAIT: begin
                    io_en_d = (kind_q == XFER_RD) ? 8'h00 : 8'hFF;
                end
                ST_DATA: begin
                    if (idx_d < IDX_W'(dlen_q)) begin
                        if (kind_q != XFER_RD) begin
                            io_en_d  = 8'hFF;
                            io_out_d = 8'(wdata_q >> (8 * int'(idx_d)));
                        end
                    end else begin
                        io_en_d = 8'hFF;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            psram_ce_o     <= 1'b1;
            psram_io_en_o  <= 8'h00;
            psram_io_out_o <= 8'h00;
            done_o         <= 1'b0;
            rdata_o        <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            psram_ce_o     <= !(state_d inside {ST_CMD, ST_ADDR, ST_WAIT, ST_DATA});
            psram_io_en_o  <= io_en_d;
            psram_io_out_o <= io_out_d;
            done_o         <= final_edge;
            if (accept) begin
                rdata_o <= '0;
            end else if (capture) begin
                for (int k = 0; k < MAX_BYTES; k++) begin
                    if (idx_q == IDX_W'(k)) rdata_o[8*k +: 8] <= psram_io_in_i;
                end
            end
        end
    end

    // Request shadow registers are only read after an accept has loaded them, so they need no reset.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            kind_q  <= req_kind;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            pscr_q  <= pscr_i;
            cmd_q   <= req_cmd;
            wait_q  <= req_wait;
            dlen_q  <= req_dlen;
            pad_q   <= req_pad;
        end
    end

endmodule
